pc_ras_unit: RTL and testbench

PC_RAS_UNIT -- requirements
Module: pc_ras_unit

---
 rtl/pc_pkg.sv | 10 +
 rtl/pc_ras.sv | 53 +++++
 rtl/pc_ras_unit.sv | 70 +++++++
 tb/tb_pc_ras_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared op encodings for the PC / return-address-stack unit.
package pc_pkg;
    localparam int OP_W = 3;
    typedef logic [OP_W-1:0] op_t;
    localparam op_t OP_INC    = 3'd0;
    localparam op_t OP_JUMP   = 3'd1;
    localparam op_t OP_BRANCH = 3'd2;
    localparam op_t OP_CALL   = 3'd3;
    localparam op_t OP_RET    = 3'd4;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [CW-1:0]    count;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    // wp is the next free slot, so the newest entry sits just below it
    assign top   = mem[wp - PW'(1)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ovf <= push && full;
            unf <= pop && !push && empty;
            if (push) begin
                wp <= wp + PW'(1);
                if (!full)
                    count <= count + CW'(1);
            end else if (pop && !empty) begin
                wp    <= wp - PW'(1);
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= push_data;
    end
endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with next-PC mux, sequential adder and a return-address stack.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               STEP     = 4,
    parameter int               DEPTH    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk_w_i,
    input  logic             res_w_i_h,
    input  logic [OP_W-1:0]  op_w_i,
    input  logic             stall_w_i,
    input  logic [WIDTH-1:0] target_w_i,
    input  logic [WIDTH-1:0] offset_w_i,
    output logic [WIDTH-1:0] pc_w_o,
    output logic             ras_empty_w_o,
    output logic             ras_full_w_o,
    output logic             ovf_w_o,
    output logic             unf_w_o
);
    logic [WIDTH-1:0] pc, pc_seq, pc_nxt, ras_top;
    logic             push, pop, ras_empty;

    assign pc_seq = pc + WIDTH'(STEP);

    always_comb begin
        push   = 1'b0;
        pop    = 1'b0;
        pc_nxt = pc;
        if (!stall_w_i) begin
            case (op_t'(op_w_i))
                OP_JUMP:   pc_nxt = target_w_i;
                OP_BRANCH: pc_nxt = pc + offset_w_i;
                OP_CALL: begin
                    push   = 1'b1;
                    pc_nxt = target_w_i;
                end
                OP_RET: begin
                    pop    = 1'b1;
                    pc_nxt = ras_empty ? pc_seq : ras_top;
                end
                default:   pc_nxt = pc_seq;
            endcase
        end
    end

    always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
        if (res_w_i_h)
            pc <= RESET_PC;
        else
            pc <= pc_nxt;
    end

    pc_ras #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ras (
        .clk       (clk_w_i),
        .rst       (res_w_i_h),
        .push      (push),
        .pop       (pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full_w_o),
        .ovf       (ovf_w_o),
        .unf       (unf_w_o)
    );

    assign pc_w_o        = pc;
    assign ras_empty_w_o = ras_empty;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: queue-based reference model checked every cycle plus literal expectations.
module tb_pc_ras_unit;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  op = 3'd0;
    logic        stall = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] offset = '0;
    logic [31:0] pc;
    logic        ras_empty, ras_full, ovf, unf;

    int errors = 0;
    int checks = 0;

    pc_ras_unit #(.WIDTH(32), .STEP(4), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_w_i       (clk),
        .res_w_i_h     (rst),
        .op_w_i        (op),
        .stall_w_i     (stall),
        .target_w_i    (target),
        .offset_w_i    (offset),
        .pc_w_o        (pc),
        .ras_empty_w_o (ras_empty),
        .ras_full_w_o  (ras_full),
        .ovf_w_o       (ovf),
        .unf_w_o       (unf)
    );

    always #5 clk = ~clk;

    // Reference model: the stack is a queue, newest at the back
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_stk[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = RESET_PC;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
            if (!stall) begin
                case (op)
                    3'd1: m_pc = target;
                    3'd2: m_pc = m_pc + offset;
                    3'd3: begin
                        if (m_stk.size() == DEPTH) begin
                            void'(m_stk.pop_front());
                            m_ovf = 1'b1;
                        end
                        m_stk.push_back(m_pc + 32'd4);
                        m_pc = target;
                    end
                    3'd4: begin
                        if (m_stk.size() == 0) begin
                            m_unf = 1'b1;
                            m_pc  = m_pc + 32'd4;
                        end else begin
                            m_pc = m_stk.pop_back();
                        end
                    end
                    default: m_pc = m_pc + 32'd4;
                endcase
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("model_pc", pc, m_pc);
        cmp("model_empty", 32'(ras_empty), 32'(m_stk.size() == 0));
        cmp("model_full", 32'(ras_full), 32'(m_stk.size() == DEPTH));
        cmp("model_ovf", 32'(ovf), 32'(m_ovf));
        cmp("model_unf", 32'(unf), 32'(m_unf));
    end

    // Inputs change just after a falling edge; returns at the next falling edge
    task automatic step(input logic [2:0] o, input logic [31:0] t, input logic [31:0] f, input logic s);
        op = o;
        target = t;
        offset = f;
        stall = s;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        cmp("reset_pc", pc, 32'h0);
        cmp("reset_empty", 32'(ras_empty), 32'd1);
        cmp("reset_full", 32'(ras_full), 32'd0);
        cmp("reset_flags", {30'd0, ovf, unf}, 32'd0);
        rst = 1'b0;

        step(3'd0, '0, '0, 1'b0); cmp("inc1", pc, 32'h4);
        step(3'd0, '0, '0, 1'b0); cmp("inc2", pc, 32'h8);
        step(3'd0, '0, '0, 1'b0); cmp("inc3", pc, 32'hC);
        cmp("inc_empty", 32'(ras_empty), 32'd1);

        step(3'd1, 32'h100, '0, 1'b0);  cmp("jump", pc, 32'h100);
        step(3'd3, 32'h2000, '0, 1'b0); cmp("call", pc, 32'h2000);
        cmp("call_nonempty", 32'(ras_empty), 32'd0);
        step(3'd4, '0, '0, 1'b0);       cmp("ret", pc, 32'h104);
        cmp("ret_empty", 32'(ras_empty), 32'd1);

        step(3'd1, 32'h100, '0, 1'b0);
        step(3'd2, '0, 32'hFFFF_FFF0, 1'b0); cmp("branch_neg", pc, 32'hF0);
        step(3'd1, 32'hFFFF_FFFC, '0, 1'b0);
        step(3'd0, '0, '0, 1'b0);            cmp("inc_wrap", pc, 32'h0);
        step(3'd6, '0, '0, 1'b0);            cmp("op6_as_inc", pc, 32'h4);
        step(3'd1, 32'h0, '0, 1'b0);

        for (int i = 1; i <= 9; i++) begin
            step(3'd3, 32'(i * 16), '0, 1'b0);
            if (i == 8) cmp("full_no_ovf", {30'd0, ras_full, ovf}, 32'd2);
        end
        cmp("ovf_pc", pc, 32'h90);
        cmp("ovf_pulse", 32'(ovf), 32'd1);
        cmp("ovf_full", 32'(ras_full), 32'd1);
        step(3'd4, '0, '0, 1'b0); cmp("ret_first", pc, 32'h84);
        cmp("ovf_cleared", 32'(ovf), 32'd0);
        for (int i = 2; i <= 8; i++) step(3'd4, '0, '0, 1'b0);
        cmp("ret_last", pc, 32'h14);
        cmp("ret_last_unf", 32'(unf), 32'd0);
        step(3'd4, '0, '0, 1'b0); cmp("unf_pc", pc, 32'h18);
        cmp("unf_pulse", 32'(unf), 32'd1);
        step(3'd0, '0, '0, 1'b0); cmp("unf_cleared", 32'(unf), 32'd0);

        for (int i = 0; i < 5; i++) begin
            step(3'd3, 32'h5000, '0, 1'b1);
            cmp("stall_call_pc", pc, 32'h1C);
            cmp("stall_call_state", {29'd0, ras_empty, ovf, unf}, 32'd4);
        end
        step(3'd4, '0, '0, 1'b1);
        cmp("stall_ret_unf", 32'(unf), 32'd0);

        for (int i = 1; i <= 3; i++) step(3'd3, 32'(i * 32'h1000), '0, 1'b0);
        op = 3'd3;
        stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        cmp("async_rst_pc", pc, RESET_PC);
        cmp("async_rst_empty", 32'(ras_empty), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        step(3'd4, '0, '0, 1'b0);
        cmp("post_rst_unf", 32'(unf), 32'd1);
        cmp("post_rst_pc", pc, RESET_PC + 32'd4);

        for (int i = 0; i < 10000; i++) begin
            int r;
            logic [2:0] o;
            r = int'($urandom_range(0, 9));
            if (r < 3)      o = 3'd3;
            else if (r < 6) o = 3'd4;
            else            o = 3'($urandom_range(0, 7));
            step(o, $urandom, $urandom, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
